// File: rtl/mc_alu_if.sv
// Bus bundle for mc_alu: request, operands and registered result/status.
interface mc_alu_if #(
  parameter int N = 64
);
  logic         Start;
  logic [3:0]   ALUCtrl;
  logic [N-1:0] BusA;
  logic [N-1:0] BusB;
  logic [N-1:0] BusW;
  logic         Zero;
  logic         Carry;
  logic         Busy;
  logic         Done;

  // Requester side: issues operations, observes results.
  modport master (
    output Start, ALUCtrl, BusA, BusB,
    input  BusW, Zero, Carry, Busy, Done
  );

  // ALU side: accepts operations, produces results.
  modport slave (
    input  Start, ALUCtrl, BusA, BusB,
    output BusW, Zero, Carry, Busy, Done
  );
endinterface

// File: rtl/mc_alu.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus an N-iteration
// shift-and-add unsigned multiplier. Results are registered and marked
// by a one-cycle Done pulse; Zero follows the registered result.
module mc_alu #(
  parameter int N    = 64,
  parameter int CNTW = 7
) (
  input  logic     CLK,
  input  logic     resetl,
  mc_alu_if.slave  bus
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_MOVZ  = 4'b1000;
  localparam logic [3:0] OP_MUL   = 4'b1001;

  // MOVZ keeps the low 16 bits of B, or all of B when N is narrower.
  localparam int MZW = (N < 16) ? N : 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_FIN
  } state_t;

  state_t          state;
  logic [N-1:0]    w_reg;
  logic            carry_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [N-1:0]    acc;
  logic [N-1:0]    mcand;
  logic [N-1:0]    mplier;
  logic [CNTW-1:0] cnt;

  logic [N:0]      sum;
  logic [N:0]      diff;
  logic [N-1:0]    alu_w;
  logic            alu_c;

  // (N+1)-bit adders: the top bit is carry-out for ADD, not-borrow for SUB.
  assign sum  = {1'b0, bus.BusA} + {1'b0, bus.BusB};
  assign diff = {1'b0, bus.BusA} + {1'b0, ~bus.BusB} + {{N{1'b0}}, 1'b1};

  // Single-cycle result selection from the live operands at the accepting edge.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    alu_w = '0;
    alu_c = 1'b0;
    unique case (bus.ALUCtrl)
      OP_AND:   alu_w = bus.BusA & bus.BusB;
      OP_OR:    alu_w = bus.BusA | bus.BusB;
      OP_ADD:   begin alu_w = sum[N-1:0];  alu_c = sum[N];  end
      OP_SUB:   begin alu_w = diff[N-1:0]; alu_c = diff[N]; end
      OP_PASSB: alu_w = bus.BusB;
      OP_MOVZ:  alu_w[MZW-1:0] = bus.BusB[MZW-1:0];
      default:  ; // unlisted opcodes (and MUL, handled by the FSM) give zero
    endcase
  end

  // Control FSM with registered result, status and multiplier datapath.
  // NOTE: non-blocking assignments throughout, so every register samples the
  // pre-edge values of the others regardless of statement order.
  always_ff @(posedge CLK or negedge resetl) begin
    // NOTE: the multiplier working registers are reset as well, so an aborted
    // multiply leaves no stale operands behind.
    if (!resetl) begin
      state     <= S_IDLE;
      w_reg     <= '0;
      carry_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      done_reg <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.Start) begin
            if (bus.ALUCtrl == OP_MUL) begin
              state    <= S_MUL;
              busy_reg <= 1'b1;
              acc      <= '0;
              cnt      <= '0;
              mcand    <= bus.BusA;
              mplier   <= bus.BusB;
            end else begin
              w_reg     <= alu_w;
              carry_reg <= alu_c;
              done_reg  <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (mplier[0]) begin
            acc <= acc + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNTW'(N - 1)) begin
            state <= S_FIN;
          end
        end
        S_FIN: begin
          w_reg     <= acc;
          carry_reg <= 1'b0;
          done_reg  <= 1'b1;
          busy_reg  <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.BusW  = w_reg;
  assign bus.Zero  = (w_reg == '0);
  assign bus.Carry = carry_reg;
  assign bus.Busy  = busy_reg;
  assign bus.Done  = done_reg;

endmodule

// File: tb/tb_mc_alu.sv
// Self-checking bench for mc_alu (N=64): transaction-level reference model,
// per-cycle output comparison, directed corner cases and random traffic.
module tb_mc_alu;

  localparam int N = 64;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_MOVZ  = 4'b1000;
  localparam logic [3:0] OP_MUL   = 4'b1001;
  localparam logic [3:0] OP_BAD   = 4'b1111;

  logic CLK = 1'b0;
  logic resetl = 1'b0;

  mc_alu_if #(.N(N)) bus ();

  mc_alu #(.N(N), .CNTW(7)) dut (
    .CLK    (CLK),
    .resetl (resetl),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: returns {carry, result} of a single-cycle op.
  function automatic logic [64:0] ref_op(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] w;
    logic        c;
    w = '0;
    c = 1'b0;
    case (op)
      OP_AND:   w = a & b;
      OP_OR:    w = a | b;
      OP_ADD:   begin w = a + b; c = ((a + b) < a); end
      OP_SUB:   begin w = a - b; c = (a >= b); end
      OP_PASSB: w = b;
      OP_MOVZ:  w = b & 64'hFFFF;
      default:  w = '0;
    endcase
    return {c, w};
  endfunction

  // Model state: visible outputs plus a countdown to a pending MUL result.
  logic [63:0] m_w;
  logic        m_c;
  logic        m_busy;
  logic        m_done;
  int          m_rem;
  logic [63:0] m_pending;

  always @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      m_w = '0; m_c = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_rem = 0; m_pending = '0;
    end else begin
      m_done = 1'b0;
      if (m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin
          m_w = m_pending; m_c = 1'b0; m_done = 1'b1; m_busy = 1'b0;
        end
      end else if (bus.Start) begin
        if (bus.ALUCtrl == OP_MUL) begin
          m_pending = bus.BusA * bus.BusB;
          m_rem     = N + 1;
          m_busy    = 1'b1;
        end else begin
          {m_c, m_w} = ref_op(bus.ALUCtrl, bus.BusA, bus.BusB);
          m_done = 1'b1;
        end
      end
    end
  end

  // Every cycle, away from the active edge, compare all outputs to the model.
  always @(negedge CLK) begin
    check("cyc_busw",  bus.BusW,  m_w);
    check("cyc_zero",  64'(bus.Zero),  64'(m_w == 64'd0));
    check("cyc_carry", 64'(bus.Carry), 64'(m_c));
    check("cyc_busy",  64'(bus.Busy),  64'(m_busy));
    check("cyc_done",  64'(bus.Done),  64'(m_done));
  end

  // Pulse Start for one accepting edge; returns at the next negedge.
  task automatic issue(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
    @(negedge CLK);
    bus.Start = 1'b1; bus.ALUCtrl = op; bus.BusA = a; bus.BusB = b;
    @(negedge CLK);
    bus.Start = 1'b0;
  endtask

  // Wait (bounded) for Done after a MUL accept; cyc counts negedges after accept.
  task automatic wait_done(output int cyc, output int busy_cyc, input bit poke_add);
    cyc = 0;
    busy_cyc = 0;
    while (!bus.Done && cyc < 200) begin
      if (bus.Busy) busy_cyc++;
      if (poke_add && cyc == 20) begin
        bus.Start = 1'b1; bus.ALUCtrl = OP_ADD; bus.BusA = 64'd1; bus.BusB = 64'd1;
      end else begin
        bus.Start = 1'b0;
      end
      if (cyc == 30) begin
        bus.BusA = {$urandom, $urandom};
        bus.BusB = {$urandom, $urandom};
      end
      @(negedge CLK);
      cyc++;
    end
  endtask

  logic [3:0] ops [8] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_PASSB, OP_MOVZ, OP_MUL, OP_BAD};

  initial begin
    int cyc, busy_cyc;
    logic [63:0] a, b;
    bus.Start = 1'b0; bus.ALUCtrl = '0; bus.BusA = '0; bus.BusB = '0;

    // Reset state
    repeat (2) @(negedge CLK);
    check("rst_busw", bus.BusW, 64'd0);
    check("rst_zero", 64'(bus.Zero), 64'd1);
    check("rst_busy", 64'(bus.Busy), 64'd0);
    check("rst_done", 64'(bus.Done), 64'd0);
    resetl = 1'b1;

    // ADD wrap with carry
    issue(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    check("add_busw",  bus.BusW, 64'd0);
    check("add_zero",  64'(bus.Zero), 64'd1);
    check("add_carry", 64'(bus.Carry), 64'd1);
    check("add_done",  64'(bus.Done), 64'd1);
    @(negedge CLK);
    check("add_done_pulse", 64'(bus.Done), 64'd0);

    // SUB borrow / no borrow
    issue(OP_SUB, 64'd5, 64'd7);
    check("sub57_busw",  bus.BusW, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sub57_carry", 64'(bus.Carry), 64'd0);
    check("sub57_zero",  64'(bus.Zero), 64'd0);
    issue(OP_SUB, 64'd7, 64'd5);
    check("sub75_busw",  bus.BusW, 64'd2);
    check("sub75_carry", 64'(bus.Carry), 64'd1);

    // MOVZ / PASSB
    issue(OP_MOVZ, 64'd0, 64'h1234_5678_9ABC_DEF0);
    check("movz_busw", bus.BusW, 64'h0000_0000_0000_DEF0);
    issue(OP_PASSB, 64'd0, 64'h1234_5678_9ABC_DEF0);
    check("passb_busw", bus.BusW, 64'h1234_5678_9ABC_DEF0);

    // MUL with ignored mid-multiply ADD and input changes
    issue(OP_MUL, 64'h1_0000_0001, 64'h3);
    wait_done(cyc, busy_cyc, 1'b1);
    check("mul_latency",   64'(cyc), 64'd65);
    check("mul_busy_cyc",  64'(busy_cyc), 64'd65);
    check("mul_busw",      bus.BusW, 64'h3_0000_0003);
    check("mul_carry",     64'(bus.Carry), 64'd0);
    bus.Start = 1'b0;
    @(negedge CLK);
    check("mul_no_queue", 64'(bus.Done), 64'd0);

    // Reset abort mid-multiply
    issue(OP_MUL, 64'd7, 64'd9);
    repeat (9) @(negedge CLK);
    #2 resetl = 1'b0;
    #1;
    check("abort_busw",  bus.BusW, 64'd0);
    check("abort_zero",  64'(bus.Zero), 64'd1);
    check("abort_busy",  64'(bus.Busy), 64'd0);
    check("abort_done",  64'(bus.Done), 64'd0);
    check("abort_carry", 64'(bus.Carry), 64'd0);
    @(negedge CLK);
    resetl = 1'b1;
    issue(OP_MUL, 64'd7, 64'd9);
    wait_done(cyc, busy_cyc, 1'b0);
    check("mul79_busw", bus.BusW, 64'd63);

    // Unlisted opcode
    issue(OP_BAD, {$urandom, $urandom}, {$urandom, $urandom});
    check("bad_busw", bus.BusW, 64'd0);
    check("bad_zero", 64'(bus.Zero), 64'd1);
    check("bad_done", 64'(bus.Done), 64'd1);

    // Back-to-back AND then OR with Start held
    @(negedge CLK);
    bus.Start = 1'b1; bus.ALUCtrl = OP_AND; bus.BusA = 64'hF0F0; bus.BusB = 64'hFF00;
    @(negedge CLK);
    check("b2b_and_done", 64'(bus.Done), 64'd1);
    check("b2b_and_busw", bus.BusW, 64'hF000);
    bus.ALUCtrl = OP_OR;
    @(negedge CLK);
    bus.Start = 1'b0;
    check("b2b_or_done", 64'(bus.Done), 64'd1);
    check("b2b_or_busw", bus.BusW, 64'hFFF0);

    // Random traffic, checked every cycle against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK);
      bus.Start   = 1'($urandom_range(0, 1));
      bus.ALUCtrl = ops[$urandom_range(0, 7)];
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) a = 64'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) b = ($urandom_range(0, 1) == 0) ? a : 64'($urandom_range(0, 3));
      bus.BusA = a;
      bus.BusB = b;
    end
    @(negedge CLK);
    bus.Start = 1'b0;
    repeat (70) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
